// File: rtl/uart_tx_fifo.sv
// UART transmitter with a configurable frame format and an input FIFO.
// Queued words are sent back-to-back with no idle gap between frames.
module uart_tx_fifo #(
    parameter int CLOCK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE     = 115_200,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                          s_axis_aclk,
    input  logic                          s_axis_aresetn,
    input  logic                          s_axis_tvalid,
    input  logic [DATA_BITS-1:0]          s_axis_tdata,
    output logic                          s_axis_tready,
    output logic                          tx_bit,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int BIT_CYC = CLOCK_FREQ_HZ / BAUD_RATE;
    localparam int CW      = $clog2(BIT_CYC);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int LW      = AW + 1;
    localparam int BW      = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [CW-1:0]          baud_q;
    logic [BW-1:0]          bit_q;
    logic                   stop_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_q;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_q;
    logic [AW-1:0]          rd_q;
    logic [LW-1:0]          level_q;
    logic [DATA_BITS-1:0]   head;
    logic                   pop;
    logic                   push;
    logic                   bit_end;
    logic                   not_empty;
    logic                   full;
    logic                   last_data;
    logic                   last_stop;

    assign head          = mem[rd_q];
    assign bit_end       = (baud_q == CW'(BIT_CYC - 1));
    assign not_empty     = (level_q != '0);
    assign full          = (level_q == LW'(FIFO_DEPTH));
    assign last_data     = (bit_q == BW'(DATA_BITS - 1));
    assign last_stop     = (stop_q == 1'(STOP_BITS - 1));
    assign s_axis_tready = s_axis_aresetn && !full;
    assign push          = s_axis_tvalid && s_axis_tready;
    assign tx_busy       = (state_q != S_IDLE) || not_empty;
    assign fifo_level    = level_q;

    // Next-state logic; a pop happens when a new frame is started.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (not_empty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end && last_data)
                    state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_end && last_stop) begin
                    if (not_empty) begin
                        pop     = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) state_q <= S_IDLE;
        else                 state_q <= state_d;
    end

    // Baud counter, bit/stop counters, shift register and parity bit.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
        end else begin
            if (state_q == S_IDLE || bit_end) baud_q <= '0;
            else                              baud_q <= baud_q + 1'b1;
            if (state_q != S_DATA) bit_q <= '0;
            else if (bit_end)      bit_q <= bit_q + 1'b1;
            if (state_q != S_STOP) stop_q <= 1'b0;
            else if (bit_end)      stop_q <= ~stop_q;
            if (pop) begin
                shift_q <= head;
                par_q   <= (PARITY == 2) ? ~^head : ^head;
            end else if (state_q == S_DATA && bit_end) begin
                shift_q <= shift_q >> 1;
            end
        end
    end

    // FIFO storage; words are captured at push time.
    always_ff @(posedge s_axis_aclk) begin
        if (push) mem[wr_q] <= s_axis_tdata;
    end

    // FIFO pointers and fill level.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            if (push && !pop)      level_q <= level_q + 1'b1;
            else if (!push && pop) level_q <= level_q - 1'b1;
        end
    end

    // Line decode from registered state only.
    always_comb begin
        tx_bit = 1'b1;
        unique case (state_q)
            S_IDLE:   tx_bit = 1'b1;
            S_START:  tx_bit = 1'b0;
            S_DATA:   tx_bit = shift_q[0];
            S_PARITY: tx_bit = par_q;
            S_STOP:   tx_bit = 1'b1;
            default:  tx_bit = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8E1, 8O1, 7N2 and 8N1/depth-4 instances.
// Line bits are recorded each negedge and compared against hand-built frames.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tdata = 8'h00;
    logic [3:0] tv = 4'h0;
    logic [3:0] rdy;
    logic [3:0] tx;
    logic [3:0] busy;
    logic [4:0] lv0;
    logic [4:0] lv1;
    logic [4:0] lv2;
    logic [2:0] lv3;

    int   n_chk = 0;
    int   n_err = 0;
    int   sel = 0;
    bit   rec = 1'b0;
    logic q[$];
    int   acc;

    uart_tx_fifo #(
        .CLOCK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
        .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)
    ) u_8e1 (
        .s_axis_aclk(clk), .s_axis_aresetn(rst_n), .s_axis_tvalid(tv[0]),
        .s_axis_tdata(tdata), .s_axis_tready(rdy[0]), .tx_bit(tx[0]),
        .tx_busy(busy[0]), .fifo_level(lv0)
    );

    uart_tx_fifo #(
        .CLOCK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)
    ) u_8o1 (
        .s_axis_aclk(clk), .s_axis_aresetn(rst_n), .s_axis_tvalid(tv[1]),
        .s_axis_tdata(tdata), .s_axis_tready(rdy[1]), .tx_bit(tx[1]),
        .tx_busy(busy[1]), .fifo_level(lv1)
    );

    uart_tx_fifo #(
        .CLOCK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7),
        .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)
    ) u_7n2 (
        .s_axis_aclk(clk), .s_axis_aresetn(rst_n), .s_axis_tvalid(tv[2]),
        .s_axis_tdata(tdata[6:0]), .s_axis_tready(rdy[2]), .tx_bit(tx[2]),
        .tx_busy(busy[2]), .fifo_level(lv2)
    );

    uart_tx_fifo #(
        .CLOCK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_8n1 (
        .s_axis_aclk(clk), .s_axis_aresetn(rst_n), .s_axis_tvalid(tv[3]),
        .s_axis_tdata(tdata), .s_axis_tready(rdy[3]), .tx_bit(tx[3]),
        .tx_busy(busy[3]), .fifo_level(lv3)
    );

    always #5 clk = ~clk;

    // Line recorder for the selected instance.
    always @(negedge clk) begin
        if (rec) q.push_back(tx[sel]);
    end

    // Handshake counter for the depth-4 instance.
    always @(negedge clk) begin
        if (tv[3] && rdy[3]) acc <= acc + 1;
    end

    function automatic logic [31:0] level(int i);
        case (i)
            0:       return 32'(lv0);
            1:       return 32'(lv1);
            2:       return 32'(lv2);
            default: return 32'(lv3);
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // q[1] is the sample after the push edge, q[2] the first start-bit cycle.
    task automatic chk_frame(string tag, int nb, logic [31:0] exp);
        int cnt;
        check({tag, "_pre"}, 32'(q[1]), 32'd1);
        for (int k = 0; k < nb; k++) begin
            cnt = 0;
            for (int j = 0; j < 10; j++)
                if (q[2 + k * 10 + j] === exp[k]) cnt++;
            check($sformatf("%s_b%0d", tag, k), 32'(cnt), 32'd10);
        end
        check({tag, "_post"}, 32'(q[2 + nb * 10]), 32'd1);
    endtask

    task automatic single(int i, logic [7:0] d, int nb,
                          logic [31:0] exp, string tag);
        @(posedge clk); #1;
        sel = i;
        q.delete();
        rec = 1'b1;
        tdata = d;
        tv[i] = 1'b1;
        @(posedge clk); #1;
        tv[i] = 1'b0;
        tdata = ~d;
        check({tag, "_lvl_push"}, level(i), 32'd1);
        check({tag, "_busy_push"}, 32'(busy[i]), 32'd1);
        @(posedge clk); #1;
        check({tag, "_lvl_pop"}, level(i), 32'd0);
        check({tag, "_start"}, 32'(tx[i]), 32'd0);
        repeat (nb * 10 - 1) @(posedge clk);
        #1;
        check({tag, "_busy_last"}, 32'(busy[i]), 32'd1);
        @(posedge clk); #1;
        check({tag, "_busy_end"}, 32'(busy[i]), 32'd0);
        @(posedge clk); #1;
        rec = 1'b0;
        chk_frame(tag, nb, exp);
    endtask

    initial begin
        logic [31:0] e;
        int          exp5 [5];
        int          base;
        int          lows;

        #2;
        check("rst_tx", 32'(tx), 32'hF);
        check("rst_rdy", 32'(rdy), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_lvl", level(3), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_rdy", 32'(rdy), 32'hF);
        check("idle_tx", 32'(tx), 32'hF);

        e = 32'({1'b1, 1'b0, 8'hA5, 1'b0});
        single(0, 8'hA5, 11, e, "t1_8e1");
        e = 32'({1'b1, 1'b1, 8'h00, 1'b0});
        single(1, 8'h00, 11, e, "t2_8o1");
        e = 32'({2'b11, 7'h55, 1'b0});
        single(2, 8'h55, 10, e, "t3_7n2");

        @(posedge clk); #1;
        sel = 3;
        q.delete();
        rec = 1'b1;
        tdata = 8'h3C;
        tv[3] = 1'b1;
        @(posedge clk); #1;
        tdata = 8'hC3;
        check("t4_lvl0", level(3), 32'd1);
        @(posedge clk); #1;
        tdata = 8'h81;
        check("t4_lvl1", level(3), 32'd1);
        @(posedge clk); #1;
        tv[3] = 1'b0;
        tdata = 8'hEE;
        check("t4_lvl2", level(3), 32'd2);
        repeat (298) @(posedge clk);
        #1;
        check("t4_busy_last", 32'(busy[3]), 32'd1);
        @(posedge clk); #1;
        check("t4_busy_end", 32'(busy[3]), 32'd0);
        @(posedge clk); #1;
        rec = 1'b0;
        e = 32'({1'b1, 8'h81, 1'b0, 1'b1, 8'hC3, 1'b0,
                 1'b1, 8'h3C, 1'b0});
        chk_frame("t4_b2b", 30, e);

        exp5 = '{1, 1, 2, 3, 4};
        @(posedge clk); #1;
        base = acc;
        tdata = 8'h11;
        tv[3] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("t5_lvl%0d", k), level(3), 32'(exp5[k]));
        end
        check("t5_full_rdy", 32'(rdy[3]), 32'd0);
        repeat (96) @(posedge clk);
        #1;
        check("t5_lvl_hold", level(3), 32'd4);
        check("t5_rdy_hold", 32'(rdy[3]), 32'd0);
        @(posedge clk); #1;
        tv[3] = 1'b0;
        check("t5_lvl_pop", level(3), 32'd3);
        check("t5_rdy_pop", 32'(rdy[3]), 32'd1);
        check("t5_accepted", 32'(acc - base), 32'd5);

        rst_n = 1'b0;
        #1;
        check("t5_rst_tx", 32'(tx[3]), 32'd1);
        check("t5_rst_lvl", level(3), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        @(posedge clk); #1;
        tdata = 8'h00;
        tv[3] = 1'b1;
        @(posedge clk); #1;
        tdata = 8'hFF;
        @(posedge clk); #1;
        tdata = 8'h0F;
        @(posedge clk); #1;
        tv[3] = 1'b0;
        check("t6_lvl_q", level(3), 32'd2);
        repeat (13) @(posedge clk);
        #1;
        check("t6_data_low", 32'(tx[3]), 32'd0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_tx", 32'(tx[3]), 32'd1);
        check("t6_rst_lvl", level(3), 32'd0);
        check("t6_rst_busy", 32'(busy[3]), 32'd0);
        check("t6_rst_rdy", 32'(rdy[3]), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        lows = 0;
        repeat (150) begin
            @(posedge clk); #1;
            if (tx[3] !== 1'b1 || busy[3] !== 1'b0) lows++;
        end
        check("t6_no_resume", 32'(lows), 32'd0);
        check("t6_lvl_after", level(3), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
